nonce_miner: RTL and testbench
==============================

# nonce_miner

Search controller that sits in front of `concatenador` and behind `hash` and closes the proof-of-work loop in hardware.
- Latches a 96-bit header and an 8-bit target.
- Sweeps the 32-bit nonce upward from 0, drives `concatenador`, and checks each `hash` result against the target.
- Stops on the first passing nonce or when the nonce range is exhausted.
- Replaces the bench-driven nonce stimulus with the consuming end of the header/nonce → hash → condition path.

## Interface
- `HASH_LAT`, 2: cycles from nonce/header presented on outputs until `hash_in` is valid for that nonce (≥1).
- `NONCE_MAX`, 32'hFFFF_FFFF: last nonce tried before declaring failure.
- `clk` input 1: single clock, all flops rising-edge.
- `reset` input 1: asynchronous, active-high; clears all state and outputs.
- `start` input 1: request a new search; sampled only in IDLE or DONE.
- `entry_12` input 96: header words; latched when `start` is accepted.
- `target` input 8: difficulty threshold; latched when `start` is accepted.
- `hash_in` input 24: `H_out` from `hash`.
- `selector` output 1: enable to `concatenador`; high in ISSUE and WAIT.
- `entry_12_out` output 96: latched header to `concatenador`; stable during a search.
- `nonce` output 32: current nonce to `concatenador`.
- `busy` output 1: high in ISSUE, WAIT and CHECK.
- `found` output 1: level; a passing nonce was found.
- `fail` output 1: level; `NONCE_MAX` was checked without a pass.
- `nonce_found` output 32: winning nonce, or on fail the last nonce tried (`NONCE_MAX`).
- `hash_found` output 24: `hash_in` captured at the final CHECK.

## Operation
- FSM states: IDLE, ISSUE, WAIT, CHECK, DONE.
- IDLE/DONE with `start`=1:
  - Latch `entry_12`, `target`.
  - `nonce`←0; clear `found`, `fail`, `nonce_found`, `hash_found`.
  - → ISSUE.
- ISSUE: `selector`=1; load wait counter with `HASH_LAT`−1; → WAIT.
- WAIT: hold `nonce` and `selector`; decrement the counter; at 0 → CHECK.
- CHECK: the pass condition is `hash_in[23:16] < target_q` AND `hash_in[15:8] < target_q`. Unsigned, strict; `hash_in[7:0]` is ignored.
  - Pass: capture `nonce_found`←`nonce`, `hash_found`←`hash_in`; `found`←1; → DONE.
  - No pass, `nonce`==`NONCE_MAX`: capture both the same way; `fail`←1; → DONE.
  - Otherwise: `nonce`←`nonce`+1; → ISSUE.
- DONE: results held; `selector`=0, `busy`=0; `start` restarts the search.
- `start` while busy is ignored. Input changes on `entry_12`/`target` during a search are ignored.
- Nonce never wraps: the `NONCE_MAX` check precedes the increment. With the default, 32'hFFFF_FFFF is checked and the search then fails.
- `target`=0 can never pass, so the search always ends in `fail`.

## Timing
- Reset values: state IDLE; every output 0 (including `entry_12_out` and `nonce`).
- `reset` asserted mid-search: immediate return to IDLE with all outputs 0. No result is reported.
- Per-nonce cost is `HASH_LAT`+2 cycles: 1 ISSUE + `HASH_LAT` WAIT + 1 CHECK.
- Let E0 be the edge that accepts `start`. Then:
  - Nonce k is presented from E0 + k·(`HASH_LAT`+2).
  - `found`/`fail` rise at E0 + (k+1)·(`HASH_LAT`+2), where k is the deciding nonce.
- `busy` rises at E0 and falls on the same edge that `found`/`fail` rise.
- `start` held high in DONE restarts on the next edge. A single-cycle `start` pulse suffices.

## Configuration
- `MINER_STATS_EN` defined:
  - Adds output `attempts` (32-bit): count of CHECK cycles in the current search.
  - Cleared by `reset` and by an accepted `start`; frozen in DONE.
- `MINER_STATS_EN` undefined: no `attempts` port and no counter logic. All other behaviour is identical.

## Test plan
- Bench hash model with `HASH_LAT`=2, `target`=8'h10: `hash_in`=24'hFFFFFF for nonce<5 and 24'h0A0B0C at nonce 5. Required: `found`=1 at E0+24, `nonce_found`=5, `hash_found`=24'h0A0B0C, `fail`=0, `attempts`=6.
- `NONCE_MAX`=3, `target`=8'h00, any hash. Required: `fail`=1 at E0+16, `nonce_found`=3, `nonce` never exceeds 3, `found`=0.
- Boundary compare, `target`=8'h0A: `hash_in`=24'h0A0000 fails (byte equals target); `hash_in`=24'h09_09_FF passes. Required: `found` on the second nonce.
- `reset` pulsed while in WAIT on nonce 2. Required: all outputs 0 asynchronously, state IDLE; a new `start` begins again from nonce 0.
- `start` re-pulsed while busy, with `target`/`entry_12` toggled mid-search. Required: no restart, and `entry_12_out` keeps the value latched at E0.
- From DONE, `start` with a new header. Required: `found`/`fail` clear at the accepting edge, the search restarts from nonce 0, and `entry_12_out` updates.

Source files
------------

// File: rtl/nonce_miner.sv
// Proof-of-work nonce search controller: sweeps nonces through concatenador/hash and stops on
// the first hash that beats the target. Optional MINER_STATS_EN adds an attempts counter.
module nonce_miner #(
  parameter int unsigned HASH_LAT  = 2,
  parameter logic [31:0] NONCE_MAX = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [95:0] entry_12,
  input  logic [7:0]  target,
  input  logic [23:0] hash_in,
  output logic        selector,
  output logic [95:0] entry_12_out,
  output logic [31:0] nonce,
  output logic        busy,
  output logic        found,
  output logic        fail,
  output logic [31:0] nonce_found,
`ifdef MINER_STATS_EN
  output logic [31:0] attempts,
`endif
  output logic [23:0] hash_found
);

  localparam int unsigned CntW = (HASH_LAT > 1) ? $clog2(HASH_LAT) : 1;

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StCheck, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [95:0]       entry_q, entry_d;
  logic [7:0]        target_q, target_d;
  logic [31:0]       nonce_q, nonce_d;
  logic              found_q, found_d;
  logic              fail_q, fail_d;
  logic [31:0]       nonce_found_q, nonce_found_d;
  logic [23:0]       hash_found_q, hash_found_d;
  logic              pass;
  logic              accept;

  // Strict unsigned compare on the top two bytes; the low byte does not matter.
  assign pass   = (hash_in[23:16] < target_q) && (hash_in[15:8] < target_q);
  assign accept = start && ((state_q == StIdle) || (state_q == StDone));

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    entry_d       = entry_q;
    target_d      = target_q;
    nonce_d       = nonce_q;
    found_d       = found_q;
    fail_d        = fail_q;
    nonce_found_d = nonce_found_q;
    hash_found_d  = hash_found_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          entry_d       = entry_12;
          target_d      = target;
          nonce_d       = '0;
          found_d       = 1'b0;
          fail_d        = 1'b0;
          nonce_found_d = '0;
          hash_found_d  = '0;
          state_d       = StIssue;
        end
      end
      StIssue: begin
        cnt_d   = CntW'(HASH_LAT - 1);
        state_d = StWait;
      end
      StWait: begin
        if (cnt_q == '0) state_d = StCheck;
        else             cnt_d   = cnt_q - 1'b1;
      end
      StCheck: begin
        // The limit check precedes the increment so the nonce never wraps.
        if (pass || (nonce_q == NONCE_MAX)) begin
          nonce_found_d = nonce_q;
          hash_found_d  = hash_in;
          found_d       = pass;
          fail_d        = ~pass;
          state_d       = StDone;
        end else begin
          nonce_d = nonce_q + 32'd1;
          state_d = StIssue;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      entry_q       <= '0;
      target_q      <= '0;
      nonce_q       <= '0;
      found_q       <= 1'b0;
      fail_q        <= 1'b0;
      nonce_found_q <= '0;
      hash_found_q  <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      entry_q       <= entry_d;
      target_q      <= target_d;
      nonce_q       <= nonce_d;
      found_q       <= found_d;
      fail_q        <= fail_d;
      nonce_found_q <= nonce_found_d;
      hash_found_q  <= hash_found_d;
    end
  end

`ifdef MINER_STATS_EN
  logic [31:0] attempts_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      attempts_q <= '0;
    end else if (accept) begin
      attempts_q <= '0;
    end else if (state_q == StCheck) begin
      attempts_q <= attempts_q + 32'd1;
    end
  end

  assign attempts = attempts_q;
`endif

  assign selector     = (state_q == StIssue) || (state_q == StWait);
  assign busy         = (state_q == StIssue) || (state_q == StWait) || (state_q == StCheck);
  assign entry_12_out = entry_q;
  assign nonce        = nonce_q;
  assign found        = found_q;
  assign fail         = fail_q;
  assign nonce_found  = nonce_found_q;
  assign hash_found   = hash_found_q;

  logic unused_accept;
  assign unused_accept = accept;

endmodule

// File: tb/tb_nonce_miner.sv
// Directed bench for nonce_miner: a small hash model keyed on the DUT nonce plus a second
// instance with NONCE_MAX=3 for the exhaustion path.
module tb_nonce_miner;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, start2;
  logic [95:0] entry_12;
  logic [7:0]  target;
  logic [23:0] hash_in;
  logic [23:0] hash_in2;
  logic        selector, busy, found, fail;
  logic [95:0] entry_12_out;
  logic [31:0] nonce, nonce_found;
  logic [23:0] hash_found;
  logic        selector2, busy2, found2, fail2;
  logic [95:0] entry_12_out2;
  logic [31:0] nonce2, nonce_found2;
  logic [23:0] hash_found2;
`ifdef MINER_STATS_EN
  logic [31:0] attempts, attempts2;
`endif

  int checks   = 0;
  int failures = 0;
  int mode     = 2;

  localparam logic [95:0] HdrA = 96'h0123_4567_89AB_CDEF_0011_2233;
  localparam logic [95:0] HdrB = 96'hDEAD_BEEF_CAFE_F00D_1234_5678;
  localparam logic [95:0] HdrC = 96'hA5A5_A5A5_5A5A_5A5A_FFFF_0000;

  always #5 clk = ~clk;

  // Hash model: mode 0 passes only at nonce 5, mode 1 probes the equality boundary,
  // mode 2 never passes.
  always_comb begin
    hash_in = 24'hFFFFFF;
    case (mode)
      0: hash_in = (nonce == 32'd5) ? 24'h0A0B0C : 24'hFFFFFF;
      1: hash_in = (nonce == 32'd0) ? 24'h0A0000 : 24'h0909FF;
      default: hash_in = 24'hFFFFFF;
    endcase
  end

  assign hash_in2 = 24'h000000;

  nonce_miner #(.HASH_LAT(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .entry_12     (entry_12),
    .target       (target),
    .hash_in      (hash_in),
    .selector     (selector),
    .entry_12_out (entry_12_out),
    .nonce        (nonce),
    .busy         (busy),
    .found        (found),
    .fail         (fail),
    .nonce_found  (nonce_found),
`ifdef MINER_STATS_EN
    .attempts     (attempts),
`endif
    .hash_found   (hash_found)
  );

  nonce_miner #(.HASH_LAT(2), .NONCE_MAX(32'd3)) dut2 (
    .clk          (clk),
    .reset        (reset),
    .start        (start2),
    .entry_12     (entry_12),
    .target       (8'h00),
    .hash_in      (hash_in2),
    .selector     (selector2),
    .entry_12_out (entry_12_out2),
    .nonce        (nonce2),
    .busy         (busy2),
    .found        (found2),
    .fail         (fail2),
    .nonce_found  (nonce_found2),
`ifdef MINER_STATS_EN
    .attempts     (attempts2),
`endif
    .hash_found   (hash_found2)
  );

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start(input logic [95:0] hdr, input logic [7:0] tgt);
    entry_12 = hdr;
    target   = tgt;
    start    = 1'b1;
    tick(1);
    start    = 1'b0;
  endtask

  initial begin
    int max_nonce2;
    reset    = 1'b1;
    start    = 1'b0;
    start2   = 1'b0;
    entry_12 = HdrA;
    target   = 8'h10;
    #12;
    chk("rst_selector", selector, 0);
    chk("rst_busy", busy, 0);
    chk("rst_found", found, 0);
    chk("rst_fail", fail, 0);
    chk("rst_nonce", nonce, 0);
    chk("rst_entry", entry_12_out, 0);
    chk("rst_nonce_found", nonce_found, 0);
    chk("rst_hash_found", hash_found, 0);
    reset = 1'b0;
    tick(2);

    // Pass at nonce 5: found at E0+24.
    mode = 0;
    pulse_start(HdrA, 8'h10);
    chk("t1_busy_at_e0", busy, 1);
    chk("t1_selector_at_e0", selector, 1);
    chk("t1_nonce_at_e0", nonce, 0);
    chk("t1_entry_at_e0", entry_12_out, HdrA);
    tick(3);
    chk("t1_nonce1_not_yet", nonce, 0);
    tick(1);
    chk("t1_nonce1_at_e4", nonce, 1);
    tick(19);
    chk("t1_found_early", found, 0);
    chk("t1_busy_e23", busy, 1);
    tick(1);
    chk("t1_found", found, 1);
    chk("t1_fail", fail, 0);
    chk("t1_busy_done", busy, 0);
    chk("t1_selector_done", selector, 0);
    chk("t1_nonce_found", nonce_found, 5);
    chk("t1_hash_found", hash_found, 24'h0A0B0C);
`ifdef MINER_STATS_EN
    chk("t1_attempts", attempts, 6);
`endif
    tick(3);
    chk("t1_found_held", found, 1);

    // Restart from DONE with a new header; equality must not pass.
    mode = 1;
    pulse_start(HdrB, 8'h0A);
    chk("t3_found_cleared", found, 0);
    chk("t3_fail_cleared", fail, 0);
    chk("t3_nonce_found_cleared", nonce_found, 0);
    chk("t3_nonce_restart", nonce, 0);
    chk("t3_entry_updated", entry_12_out, HdrB);
    tick(3);
    chk("t3_no_pass_on_equal", busy, 1);
    tick(4);
    chk("t3_found_early", found, 0);
    tick(1);
    chk("t3_found", found, 1);
    chk("t3_nonce_found", nonce_found, 1);
    chk("t3_hash_found", hash_found, 24'h0909FF);
`ifdef MINER_STATS_EN
    chk("t3_attempts", attempts, 2);
`endif

    // start re-pulsed mid-search with changed header/target must be ignored.
    mode = 0;
    pulse_start(HdrC, 8'h10);
    tick(5);
    entry_12 = HdrA;
    target   = 8'h00;
    start    = 1'b1;
    tick(1);
    start    = 1'b0;
    chk("t4_nonce_no_restart", nonce, 1);
    chk("t4_entry_held", entry_12_out, HdrC);
    tick(17);
    chk("t4_found_early", found, 0);
    tick(1);
    chk("t4_found", found, 1);
    chk("t4_nonce_found", nonce_found, 5);
    chk("t4_entry_final", entry_12_out, HdrC);

    // Exhaustion on the NONCE_MAX=3 instance: fail at E0+16.
    entry_12 = HdrA;
    start2   = 1'b1;
    tick(1);
    start2   = 1'b0;
    max_nonce2 = 0;
    for (int i = 1; i < 16; i++) begin
      if (int'(nonce2) > max_nonce2) max_nonce2 = int'(nonce2);
      tick(1);
    end
    chk("t2_fail_early", fail2, 0);
    tick(1);
    if (int'(nonce2) > max_nonce2) max_nonce2 = int'(nonce2);
    chk("t2_fail", fail2, 1);
    chk("t2_found", found2, 0);
    chk("t2_nonce_found", nonce_found2, 3);
    chk("t2_nonce_max_seen", max_nonce2, 3);
    chk("t2_busy", busy2, 0);

    // Asynchronous reset while waiting on nonce 2.
    mode = 2;
    pulse_start(HdrB, 8'h10);
    tick(9);
    chk("t5_in_wait_n2", nonce, 2);
    #2;
    reset = 1'b1;
    #1;
    chk("t5_rst_selector", selector, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_nonce", nonce, 0);
    chk("t5_rst_entry", entry_12_out, 0);
    chk("t5_rst_found", found, 0);
    chk("t5_rst_fail", fail, 0);
    #3;
    reset = 1'b0;
    tick(2);
    chk("t5_idle_busy", busy, 0);
    pulse_start(HdrA, 8'h10);
    chk("t5_restart_nonce", nonce, 0);
    chk("t5_restart_busy", busy, 1);
    tick(4);
    chk("t5_restart_nonce1", nonce, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
